// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller and the main decoder:
// FSM state encoding, default register-address width and MIPS opcodes.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ERROR    = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/hazard_timeout_cnt.sv
// Clearable MEM_WAIT cycle counter; terminal-count flag is combinational
// from the registered count (asserts while count == TIMEOUT-1).
module hazard_timeout_cnt #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tc_o = (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, branch/jump
// flush, freeze on data-memory wait, sticky timeout trap. Optional HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              hazard_o,
    output logic              pipe_en_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_run;
    logic       w_wait;
    logic       w_error;
    logic       w_freeze;
    logic       w_load_use;
    logic       w_tc;

    assign w_run   = (r_state == ST_RUN);
    assign w_wait  = (r_state == ST_MEM_WAIT);
    assign w_error = (r_state == ST_ERROR);

    // The ack cycle itself is never frozen: the pipeline advances with the ack.
    assign w_freeze = (w_run & mem_req_i & ~mem_ack_i) | (w_wait & ~mem_ack_i) | w_error;

    assign w_load_use = ex_memread_i & (ex_rt_i != '0) &
                        ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

    always_comb begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        hazard_o     = 1'b0;
        pipe_en_o    = 1'b0;
        if (rst_i && !w_freeze) begin
            if (w_load_use) begin
                hazard_o  = 1'b1;
                pipe_en_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                pipe_en_o    = 1'b1;
                ifid_flush_o = branch_taken_i | jump_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    w_state_nxt = ST_RUN;
                end else if (w_tc) begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counting only in MEM_WAIT and clearing elsewhere starts it at 0 on entry.
    hazard_timeout_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~w_wait),
        .inc_i (w_wait),
        .tc_o  (w_tc)
    );

    assign err_o = w_error;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (!pc_write_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle model and per-cycle compare.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [REG_AW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic              id_uses_rt = 1'b0, ex_memread = 1'b0;
    logic              branch_taken = 1'b0, jump = 1'b0;
    logic              mem_req = 1'b0, mem_ack = 1'b0;
    logic              pc_write, ifid_write, ifid_flush, hazard, pipe_en, err;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW (REG_AW), .TIMEOUT (TIMEOUT), .TO_W (TO_W), .CNT_W (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .ex_memread_i   (ex_memread),
        .ex_rt_i        (ex_rt),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .mem_req_i      (mem_req),
        .mem_ack_i      (mem_ack),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .hazard_o       (hazard),
        .pipe_en_o      (pipe_en),
        .err_o          (err),
        .stall_cnt_o    (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "waiting" = a memory access has been outstanding for one or more edges,
    // m_waited = edges spent waiting, m_err = trapped until reset.
    bit      m_waiting = 0;
    int      m_waited  = 0;
    bit      m_err     = 0;
    longint  m_stalls  = 0;

    function automatic bit m_frozen();
        if (m_err) return 1;
        return !mem_ack && (m_waiting || mem_req);
    endfunction

    function automatic bit m_load_use();
        return ex_memread && (int'(ex_rt) != 0) &&
               ((int'(ex_rt) == int'(id_rs)) || (id_uses_rt && (int'(ex_rt) == int'(id_rt))));
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, hazard, pipe_en}
    function automatic logic [4:0] m_outs();
        if (!rst_n || m_frozen()) return 5'b00000;
        if (m_load_use())         return 5'b00011;
        return {2'b11, branch_taken | jump, 2'b01};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (m_outs()[4] == 1'b0) m_stalls++;
            if (m_err) begin
                m_err = 1;
            end else if (m_waiting) begin
                if (mem_ack) begin
                    m_waiting = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= TIMEOUT) begin m_err = 1; m_waiting = 0; end
                end
            end else if (mem_req && !mem_ack) begin
                m_waiting = 1; m_waited = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        e = m_outs();
        check("cyc_pc_write",   pc_write,   e[4]);
        check("cyc_ifid_write", ifid_write, e[3]);
        check("cyc_ifid_flush", ifid_flush, e[2]);
        check("cyc_hazard",     hazard,     e[1]);
        check("cyc_pipe_en",    pipe_en,    e[0]);
        check("cyc_err",        err,        m_err);
`ifdef HAZARD_PERF_CNT_EN
        check("cyc_stall_cnt",  stall_cnt,  m_stalls);
`else
        check("cyc_stall_cnt",  stall_cnt,  0);
`endif
        if (rst_n && m_waiting && !mem_req && !mem_ack) begin
            failures++;
            $display("FAIL proto_req_dropped mem_req=0 required=1 at %0t", $time);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        branch_taken = 0; jump = 0; mem_req = 0; mem_ack = 0;
    endtask

    logic [CNT_W-1:0] s0;

    initial begin
        // Reset state
        cyc(); #2;
        check("rst_pc_write", pc_write, 0);
        check("rst_pipe_en",  pipe_en,  0);
        check("rst_err",      err,      0);
        check("rst_stall",    stall_cnt, 0);
        cyc(); rst_n = 1; #2;
        check("run_pc_write", pc_write, 1);
        check("run_pipe_en",  pipe_en,  1);

        // Load-use on rs: one stall cycle, then bubble clears EX
        cyc(); ex_memread = 1; ex_rt = 5; id_rs = 5; id_rt = 9; #2;
        check("lu_pc_write",   pc_write,   0);
        check("lu_ifid_write", ifid_write, 0);
        check("lu_hazard",     hazard,     1);
        check("lu_pipe_en",    pipe_en,    1);
        cyc(); ex_memread = 0; #2;
        check("lu_after_pc_write", pc_write, 1);
        check("lu_after_hazard",   hazard,   0);

        // Load to $0 never stalls
        cyc(); idle(); ex_memread = 1; #2;
        check("r0_hazard",   hazard,   0);
        check("r0_pc_write", pc_write, 1);

        // rt match ignored when ID does not read rt
        cyc(); idle(); ex_memread = 1; ex_rt = 7; id_rt = 7; id_rs = 3; #2;
        check("nort_hazard", hazard, 0);

        // Taken beq with rt load-use: stall beats flush, then flush
        cyc(); id_uses_rt = 1; branch_taken = 1; #2;
        check("beq_lu_flush",  ifid_flush, 0);
        check("beq_lu_hazard", hazard,     1);
        cyc(); ex_memread = 0; #2;
        check("beq_flush",    ifid_flush, 1);
        check("beq_pc_write", pc_write,   1);
        cyc(); idle(); jump = 1; #2;
        check("j_flush", ifid_flush, 1);
        cyc(); idle(); #2;
        check("idle_flush", ifid_flush, 0);

        // Memory wait: 3 frozen cycles, ack cycle advances
        cyc(); s0 = stall_cnt; mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            ex_memread = (i == 1); ex_rt = 5; id_rs = 5;
            #2;
            check("mw_pipe_en",  pipe_en,  0);
            check("mw_pc_write", pc_write, 0);
            check("mw_hazard",   hazard,   0);
            cyc();
        end
        ex_memread = 0; mem_ack = 1; #2;
        check("mw_ack_pipe_en",  pipe_en,  1);
        check("mw_ack_pc_write", pc_write, 1);
        cyc(); idle(); #2;
        check("mw_after_pc_write", pc_write, 1);
`ifdef HAZARD_PERF_CNT_EN
        check("mw_stall_plus3", stall_cnt, s0 + 3);
`endif

        // Timeout: one RUN cycle plus TIMEOUT MEM_WAIT cycles, then trap
        mem_req = 1;
        for (int i = 0; i <= TIMEOUT; i++) begin
            #2;
            check("to_err_low", err, 0);
            cyc();
        end
        #2;
        check("to_err",      err,      1);
        check("to_pc_write", pc_write, 0);
        cyc(); mem_ack = 1; #2;
        check("to_ack_err",     err,     1);
        check("to_ack_pipe_en", pipe_en, 0);
        cyc(); cyc(); idle(); rst_n = 0; #2;
        check("to_rst_err", err, 0);
        cyc(); rst_n = 1; #2;
        check("to_rst_pc_write", pc_write, 1);

        // Async reset between edges while in MEM_WAIT
        cyc(); mem_req = 1;
        cyc(); cyc(); #3;
        rst_n = 0; mem_req = 0; #2;
        check("ar_pc_write", pc_write, 0);
        check("ar_pipe_en",  pipe_en,  0);
        rst_n = 1; #2;
        check("ar_run_pc_write", pc_write, 1);
        check("ar_run_pipe_en",  pipe_en,  1);
        check("ar_run_err",      err,      0);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use hazards and drives the ID-stage hazard bubble into the main decoder. Flushes IF/ID on taken branch or jump resolved in ID. Freezes the whole pipeline while a MEM-stage data-memory access waits for acknowledge, and traps on memory timeout.

Parameters:
REG_AW, 5, register-address width
TIMEOUT, 255, max MEM_WAIT cycles before error (1..2^TO_W-1)
TO_W, 8, timeout counter width
CNT_W, 32, stall performance counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
id_rs_i  in  REG_AW  rs of instruction in ID
id_rt_i  in  REG_AW  rt of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt (R-type, beq, sw)
ex_memread_i  in  1  instruction in EX is a load
ex_rt_i  in  REG_AW  destination rt of EX load
branch_taken_i  in  1  beq resolved taken in ID
jump_i  in  1  j decoded in ID
mem_req_i  in  1  MEM stage issuing data-memory access
mem_ack_i  in  1  data memory completes access this cycle
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register enable
ifid_flush_o  out  1  IF/ID clear to nop
hazard_o  out  1  zero control signals into ID/EX (bubble)
pipe_en_o  out  1  ID/EX, EX/MEM, MEM/WB enable
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset (rst_i=0, async) -> RUN, timeout cnt=0, stall cnt=0, err_o=0.
- While rst_i=0: pc_write_o=0, ifid_write_o=0, pipe_en_o=0, ifid_flush_o=0, hazard_o=0.
- Outputs are combinational from state and inputs (zero-latency). State and counters are registered.
- freeze = (RUN & mem_req_i & ~mem_ack_i) | (MEM_WAIT & ~mem_ack_i) | ERROR.
- freeze=1: pc_write_o=0, ifid_write_o=0, pipe_en_o=0, hazard_o=0, ifid_flush_o=0. Hazards are suppressed because ID does not advance; they re-evaluate on release.
- The ack cycle is not frozen: the pipeline advances in the same cycle mem_ack_i=1.
- load_use = ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Not frozen, load_use=1: pc_write_o=0, ifid_write_o=0, hazard_o=1, pipe_en_o=1, ifid_flush_o=0. The stall lasts exactly one cycle, since the bubble clears EX.
- Not frozen, load_use=0, (branch_taken_i|jump_i)=1: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1. Load-use beats flush.
- Otherwise all enables =1, hazard_o=0, ifid_flush_o=0.
- Transitions:
  - RUN -> MEM_WAIT on mem_req_i & ~mem_ack_i.
  - MEM_WAIT -> RUN on mem_ack_i.
  - MEM_WAIT -> ERROR when timeout cnt==TIMEOUT-1 and ~mem_ack_i; ack in that same cycle wins (-> RUN).
  - ERROR is terminal until reset, with err_o=1.
- Timeout cnt: cleared on entering MEM_WAIT, increments each MEM_WAIT cycle, cleared in RUN.
- mem_req_i dropping during MEM_WAIT without ack: remain in MEM_WAIT, since requests are held by the MEM stage. Protocol violation; bench flags it.
- Reset mid-MEM_WAIT: immediate return to RUN, counters cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt_o increments, saturating at all-ones, every cycle with rst_i=1 and pc_write_o=0.
- Undefined: stall_cnt_o tied to 0 and the counter register is not built.

Decomposition:
- Shared package hazard_pkg: FSM state encoding (RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10), REG_AW default, opcode constants (R-type 000000, lw 100011, sw 101011, beq 000100, j 000010) shared with the main decoder.
- One natural sub-module, hazard_timeout_cnt: the clearable timeout counter with terminal-count flag.

Test Plan:
- Load-use: EX lw rt=5, ID add rs=5 -> one cycle with pc_write_o=0, ifid_write_o=0, hazard_o=1; next cycle all enables 1.
- Load to $0: ex_rt_i=0, id_rs_i=0, ex_memread_i=1 -> no stall, hazard_o=0.
- Taken beq with simultaneous load-use (id_rt match, id_uses_rt_i=1) -> stall wins (ifid_flush_o=0); next cycle branch_taken_i=1 -> ifid_flush_o=1 for one cycle.
- Memory wait: mem_req_i=1, ack after 3 cycles -> pipe_en_o=0 for 3 cycles, ack cycle pipe_en_o=1, state RUN; stall_cnt_o +3 with HAZARD_PERF_CNT_EN.
- Timeout: TIMEOUT=4, no ack -> err_o=1 after 4 MEM_WAIT cycles, all enables 0 permanently; rst_i low -> err_o=0, state RUN.
- Async reset asserted mid-MEM_WAIT between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.
